// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the HI/LO multiply/divide unit.
package mips_pkg;

    // Operation select presented with the E-stage request
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    // Sequencer states of the iterative unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

    // LO is filled with this bit (all ones) on divide by zero
    localparam logic DIV0_LO_FILL = 1'b1;

    // True for the two divide opcodes
    function automatic logic op_is_div(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative datapath.
// Multiply: shift-add on {hi_acc, lo_acc}, multiplier consumed from lo_acc LSB.
// Divide: restoring subtract, remainder in hi_acc, dividend/quotient in lo_acc.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_acc,
    input  logic [XLEN-1:0] lo_acc,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] add_sum_s;
    logic [XLEN:0] div_shift_s;
    logic          div_fits_s;

    // Single shift-add or restoring-subtract step
    always_comb begin
        add_sum_s   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_acc, lo_acc[XLEN-1]};
        div_fits_s  = (div_shift_s >= {1'b0, operand});
        if (is_div) begin
            if (div_fits_s) begin
                // Difference is below the divisor, so XLEN bits hold it exactly
                hi_next = div_shift_s[XLEN-1:0] - operand;
                lo_next = {lo_acc[XLEN-2:0], 1'b1};
            end else begin
                hi_next = div_shift_s[XLEN-1:0];
                lo_next = {lo_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = add_sum_s[XLEN:1];
            lo_next = {add_sum_s[0], lo_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO writes.
// Works on operand magnitudes for ITER cycles, then applies sign correction.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            cancel,
    input  logic            hlread,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int                CNT_W    = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONE_X    = XLEN'(1'b1);
    localparam logic [2*XLEN-1:0] ONE_2X   = (2*XLEN)'(1'b1);

    muldiv_state_t     state_r;
    muldiv_state_t     state_next_s;
    logic [CNT_W-1:0]  cnt_r;

    logic [XLEN-1:0]   acc_hi_r;
    logic [XLEN-1:0]   acc_lo_r;
    logic [XLEN-1:0]   opnd_r;
    logic              is_div_r;
    logic              neg_quot_r;
    logic              neg_rem_r;

    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic              done_r;

    logic              is_signed_s;
    logic              is_div_op_s;
    logic              neg_a_s;
    logic              neg_b_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;

    logic              busy_s;
    logic              stall_s;
    logic              launch_s;
    logic              div0_s;
    logic              mthi_s;
    logic              mtlo_s;
    logic              run_s;
    logic              fix_s;

    logic [XLEN-1:0]   step_hi_s;
    logic [XLEN-1:0]   step_lo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   fix_hi_s;
    logic [XLEN-1:0]   fix_lo_s;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div (is_div_r),
        .hi_acc (acc_hi_r),
        .lo_acc (acc_lo_r),
        .operand(opnd_r),
        .hi_next(step_hi_s),
        .lo_next(step_lo_s)
    );

    // Operand magnitudes and sign flags for the signed opcodes
    always_comb begin
        is_signed_s = (op == OP_MULT) || (op == OP_DIV);
        is_div_op_s = op_is_div(op);
        neg_a_s     = is_signed_s & srca[XLEN-1];
        neg_b_s     = is_signed_s & srcb[XLEN-1];
        if (neg_a_s) begin
            mag_a_s = (~srca) + ONE_X;
        end else begin
            mag_a_s = srca;
        end
        if (neg_b_s) begin
            mag_b_s = (~srcb) + ONE_X;
        end else begin
            mag_b_s = srcb;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; cancel overrides everything
    always_comb begin
        state_next_s = state_r;
        if (cancel) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = ST_FIX;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FIX:  state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: busy/stall and the per-cycle control strobes
    always_comb begin
        busy_s   = 1'b0;
        launch_s = 1'b0;
        div0_s   = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU: launch_s = 1'b1;
                        OP_DIV, OP_DIVU: begin
                            if (srcb == ZERO_X) begin
                                div0_s = 1'b1;
                            end else begin
                                launch_s = 1'b1;
                            end
                        end
                        OP_MTHI: mthi_s = 1'b1;
                        OP_MTLO: mtlo_s = 1'b1;
                        default: launch_s = 1'b0;
                    endcase
                end else begin
                    launch_s = 1'b0;
                end
            end
            ST_RUN:  busy_s = 1'b1;
            ST_FIX:  busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
        run_s   = (state_r == ST_RUN) & ~cancel;
        fix_s   = (state_r == ST_FIX) & ~cancel;
        stall_s = busy_s & (start | hlread);
    end

    // Iteration counter: counts RUN cycles, cleared whenever not running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if (run_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    // Working accumulators: loaded on launch, advanced once per RUN cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hi_r   <= ZERO_X;
            acc_lo_r   <= ZERO_X;
            opnd_r     <= ZERO_X;
            is_div_r   <= 1'b0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else if (launch_s) begin
            acc_hi_r   <= ZERO_X;
            acc_lo_r   <= mag_a_s;
            opnd_r     <= mag_b_s;
            is_div_r   <= is_div_op_s;
            neg_quot_r <= neg_a_s ^ neg_b_s;
            neg_rem_r  <= neg_a_s;
        end else if (run_s) begin
            acc_hi_r   <= step_hi_s;
            acc_lo_r   <= step_lo_s;
        end
    end

    // Sign correction of the magnitude result in FIX
    always_comb begin
        prod_s = {acc_hi_r, acc_lo_r};
        if (neg_quot_r) begin
            prod_fix_s = (~prod_s) + ONE_2X;
        end else begin
            prod_fix_s = prod_s;
        end
        if (is_div_r) begin
            // Quotient truncates toward zero; remainder follows the dividend
            if (neg_quot_r) begin
                fix_lo_s = (~acc_lo_r) + ONE_X;
            end else begin
                fix_lo_s = acc_lo_r;
            end
            if (neg_rem_r) begin
                fix_hi_s = (~acc_hi_r) + ONE_X;
            end else begin
                fix_hi_s = acc_hi_r;
            end
        end else begin
            fix_hi_s = prod_fix_s[2*XLEN-1:XLEN];
            fix_lo_s = prod_fix_s[XLEN-1:0];
        end
    end

    // Architectural HI/LO and the one-cycle done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r   <= ZERO_X;
            lo_r   <= ZERO_X;
            done_r <= 1'b0;
        end else begin
            done_r <= fix_s | div0_s;
            if (fix_s) begin
                hi_r <= fix_hi_s;
                lo_r <= fix_lo_s;
            end else if (div0_s) begin
                hi_r <= srca;
                lo_r <= {XLEN{DIV0_LO_FILL}};
            end else if (mthi_s) begin
                hi_r <= srca;
            end else if (mtlo_s) begin
                lo_r <= srca;
            end
        end
    end

    assign busy  = busy_s;
    assign stall = stall_s;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a 64-bit arithmetic
// reference model, randomized operands and directed corner scenarios.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            cancel;
    logic            hlread;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    muldiv_unit #(
        .XLEN(XLEN),
        .ITER(ITER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .cancel(cancel),
        .hlread(hlread),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural operands
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = model_hi;
        el = model_lo;
        case (o)
            OP_MULT: begin
                p = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else if (o == OP_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    el = 32'(q);
                    eh = 32'(r);
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor: every done pulse pops one expected HI/LO pair
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mon_hi", {32'd0, hi}, {32'd0, mon_exp[63:32]});
                check("mon_lo", {32'd0, lo}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    // Issue a multiply/divide from a negedge and wait (bounded) for done
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
        int          exp_lat;
        bit          saw_busy;
        model(o, a, b, eh, el);
        exp_q.push_back({eh, el});
        exp_lat  = (b == 32'd0) && (o == OP_DIV || o == OP_DIVU) ? 1 : ITER + 2;
        start    = 1'b1;
        op       = o;
        srca     = a;
        srcb     = b;
        lat      = 0;
        saw_busy = 1'b0;
        while (lat < ITER + 10) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) saw_busy = 1'b1;
            if (done) break;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_seen", {63'd0, saw_busy}, {63'd0, exp_lat != 1});
        check("busy_after_done", {63'd0, busy}, 64'd0);
        model_hi = eh;
        model_lo = el;
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    // MTHI/MTLO: write lands at the next edge with no busy and no done
    task automatic mt_op(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (o == OP_MTHI) model_hi = a;
        else model_lo = a;
        check("mt_hi", {32'd0, hi}, {32'd0, model_hi});
        check("mt_lo", {32'd0, lo}, {32'd0, model_lo});
        check("mt_busy", {63'd0, busy}, 64'd0);
        check("mt_done", {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic [2:0]  o;
        bit          saw_done;

        reset  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        srca   = 32'd0;
        srcb   = 32'd0;
        cancel = 1'b0;
        hlread = 1'b0;
        #2;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed arithmetic corners
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU,  32'd100,       32'd7);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIVU,  32'd5,         32'd0);
        run_op(OP_DIV,   32'h8000_0001, 32'd0);
        mt_op(OP_MTHI, 32'hA5A5_0001);
        mt_op(OP_MTLO, 32'h5A5A_0002);

        // hlread from cycle 10 stalls until done; a start while busy is ignored
        model(OP_MULT, 32'h1234_5678, 32'h8765_4321, eh, el);
        exp_q.push_back({eh, el});
        start = 1'b1;
        op    = OP_MULT;
        srca  = 32'h1234_5678;
        srcb  = 32'h8765_4321;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= ITER + 2; k++) begin
            @(negedge clk);
            if (k == 10) hlread = 1'b1;
            if (k == 12) begin
                start = 1'b1;
                op    = OP_MTHI;
                srca  = 32'hDEAD_BEEF;
            end
            if (k == 16) start = 1'b0;
            if (k >= 10) begin
                #1;
                check("stall", {63'd0, stall}, {63'd0, k < ITER + 2});
            end
            if (k == 20) check("hi_held_while_busy", {32'd0, hi}, {32'd0, model_hi});
        end
        check("stall_test_done", {63'd0, done}, 64'd1);
        hlread   = 1'b0;
        model_hi = eh;
        model_lo = el;
        @(negedge clk);

        // cancel during RUN cycle 15
        start = 1'b1;
        op    = OP_DIVU;
        srca  = 32'hFFFF_0000;
        srcb  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_hi", {32'd0, hi}, {32'd0, model_hi});
        check("cancel_lo", {32'd0, lo}, {32'd0, model_lo});
        saw_done = 1'b0;
        repeat (ITER + 4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("cancel_no_done", {63'd0, saw_done}, 64'd0);

        // Randomized operations, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(o, a, b);
            if ($urandom_range(0, 4) == 0) mt_op(3'($urandom_range(4, 5)), $urandom);
        end

        // Reset during RUN cycle 5, then MTLO right after release
        mt_op(OP_MTHI, 32'h0BAD_F00D);
        start = 1'b1;
        op    = OP_MULT;
        srca  = 32'h7;
        srcb  = 32'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        hlread = 1'b1;
        reset  = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_stall", {63'd0, stall}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        hlread   = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        mt_op(OP_MTLO, 32'h0000_1234);
        run_op(OP_MULTU, 32'd3, 32'd5);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
